// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the 8-bit bus CPU control path.
//   opcode_t    - instruction opcodes held in the low OP_WIDTH bits of the IR
//   T0_FETCH..  - microstep indices
//   ctrl_word_t - every control strobe the sequencer can drive in one step
package cpu_pkg;

  localparam int OP_WIDTH = 4;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  localparam int T0_FETCH = 0;
  localparam int T1_FETCH = 1;
  localparam int T2       = 2;
  localparam int T3       = 3;
  localparam int T4       = 4;

  typedef struct packed {
    logic oe_pc;
    logic oe_ir;
    logic oe_ram;
    logic oe_a;
    logic oe_alu;
    logic load_mar;
    logic load_ir;
    logic load_a;
    logic load_b;
    logic load_out;
    logic ram_we;
    logic pc_enable;
    logic pc_load;
    logic alu_sub;
    logic flag_load;
    logic hlt;        // request to enter the halted state at the end of this step
  } ctrl_word_t;

endpackage

// File: rtl/microcode_decoder.sv
// microcode_decoder: purely combinational microcode ROM.
//   step, opcode, flag_carry, flag_zero -> ctrl (all strobes) and done
//   done marks the last step of the current instruction.
module microcode_decoder
  import cpu_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
) (
  input  logic [STEP_WIDTH-1:0]   step,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    flag_carry,
  input  logic                    flag_zero,
  output ctrl_word_t              ctrl,
  output logic                    done
);

  localparam int STEP_MAX = (1 << STEP_WIDTH) - 1;

  opcode_t op;
  logic    multi_step;
  int      step_i;

  always_comb begin
    // Any set upper opcode bit makes the instruction a NOP.
    op = ((opcode >> OP_WIDTH) == '0) ? opcode_t'(opcode[OP_WIDTH-1:0]) : OP_NOP;
    step_i = 32'(step);

    case (op)
      OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
      OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: multi_step = 1'b1;
      default:                              multi_step = 1'b0;
    endcase

    ctrl = '0;
    done = 1'b0;
    case (step_i)
      T0_FETCH: begin
        ctrl.oe_pc    = 1'b1;
        ctrl.load_mar = 1'b1;
      end
      T1_FETCH: begin
        ctrl.oe_ram    = 1'b1;
        ctrl.load_ir   = 1'b1;
        ctrl.pc_enable = 1'b1;
        done           = !multi_step;
      end
      T2: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl.oe_ir    = 1'b1;
            ctrl.load_mar = 1'b1;
          end
          OP_LDI: begin
            ctrl.oe_ir  = 1'b1;
            ctrl.load_a = 1'b1;
            done        = 1'b1;
          end
          OP_JMP: begin
            ctrl.oe_ir   = 1'b1;
            ctrl.pc_load = 1'b1;
            done         = 1'b1;
          end
          OP_JC: begin
            ctrl.oe_ir   = 1'b1;
            ctrl.pc_load = flag_carry;
            done         = 1'b1;
          end
          OP_JZ: begin
            ctrl.oe_ir   = 1'b1;
            ctrl.pc_load = flag_zero;
            done         = 1'b1;
          end
          OP_OUT: begin
            ctrl.oe_a     = 1'b1;
            ctrl.load_out = 1'b1;
            done          = 1'b1;
          end
          OP_HLT: begin
            ctrl.hlt = 1'b1;
            done     = 1'b1;
          end
          default: ;
        endcase
      end
      T3: begin
        case (op)
          OP_LDA: begin
            ctrl.oe_ram = 1'b1;
            ctrl.load_a = 1'b1;
            done        = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl.oe_ram  = 1'b1;
            ctrl.load_b  = 1'b1;
            ctrl.alu_sub = (op == OP_SUB);
          end
          OP_STA: begin
            ctrl.oe_a   = 1'b1;
            ctrl.ram_we = 1'b1;
            done        = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        if (op == OP_ADD || op == OP_SUB) begin
          ctrl.oe_alu    = 1'b1;
          ctrl.load_a    = 1'b1;
          ctrl.flag_load = 1'b1;
          ctrl.alu_sub   = (op == OP_SUB);
          done           = 1'b1;
        end
      end
      default: ;
    endcase

    // Defensive wrap: an opcode change mid-instruction can never strand the counter.
    if (step_i == STEP_MAX) done = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: microstep counter, halt flag and reset/stall gating around
// the microcode decoder.
//   clk, reset (sync, active-low), step_en (single-step qualifier)
//   opcode, flag_carry, flag_zero        -> decode inputs
//   microstep, halted                    -> registered state
//   oe_*, load_*, ram_we, pc_*, alu_sub,
//   flag_load, instr_done                -> combinational control word
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int OPCODE_WIDTH   = 4,
  parameter int STEP_WIDTH     = 3,
  parameter int SINGLE_STEP_EN = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step_en,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    flag_carry,
  input  logic                    flag_zero,
  output logic [STEP_WIDTH-1:0]   microstep,
  output logic                    oe_pc,
  output logic                    oe_ir,
  output logic                    oe_ram,
  output logic                    oe_a,
  output logic                    oe_alu,
  output logic                    load_mar,
  output logic                    load_ir,
  output logic                    load_a,
  output logic                    load_b,
  output logic                    load_out,
  output logic                    ram_we,
  output logic                    pc_enable,
  output logic                    pc_load,
  output logic                    alu_sub,
  output logic                    flag_load,
  output logic                    instr_done,
  output logic                    halted
);

  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic                  halted_q, halted_d;
  logic                  adv, active;
  ctrl_word_t            dec_ctrl, ctrl_out;
  logic                  dec_done;

  microcode_decoder #(
    .OPCODE_WIDTH(OPCODE_WIDTH),
    .STEP_WIDTH  (STEP_WIDTH)
  ) u_decoder (
    .step      (step_q),
    .opcode    (opcode),
    .flag_carry(flag_carry),
    .flag_zero (flag_zero),
    .ctrl      (dec_ctrl),
    .done      (dec_done)
  );

  always_comb begin
    adv      = !halted_q && ((SINGLE_STEP_EN != 0) ? step_en : 1'b1);
    // Strobes only fire on cycles that actually advance, so a stall never
    // repeats a load or a PC increment.
    active   = reset && adv;
    step_d   = step_q;
    halted_d = halted_q;
    if (adv) begin
      step_d = dec_done ? '0 : step_q + 1'b1;
      if (dec_ctrl.hlt && dec_done) halted_d = 1'b1;
    end
    ctrl_out = active ? dec_ctrl : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      step_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  assign microstep  = step_q;
  assign halted     = halted_q;
  assign instr_done = active && dec_done;
  assign oe_pc      = ctrl_out.oe_pc;
  assign oe_ir      = ctrl_out.oe_ir;
  assign oe_ram     = ctrl_out.oe_ram;
  assign oe_a       = ctrl_out.oe_a;
  assign oe_alu     = ctrl_out.oe_alu;
  assign load_mar   = ctrl_out.load_mar;
  assign load_ir    = ctrl_out.load_ir;
  assign load_a     = ctrl_out.load_a;
  assign load_b     = ctrl_out.load_b;
  assign load_out   = ctrl_out.load_out;
  assign ram_we     = ctrl_out.ram_we;
  assign pc_enable  = ctrl_out.pc_enable;
  assign pc_load    = ctrl_out.pc_load;
  assign alu_sub    = ctrl_out.alu_sub;
  assign flag_load  = ctrl_out.flag_load;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Parametrised microstep sequencer and control-word generator for the 8-bit bus CPU. Replaces the inline fixed-step controller.
- Fetches through the MAR, supports variable-length instructions with early return to fetch, conditional jumps on ALU flags, halt, and single-step gating.
- Drives the output-enable and load strobes of the PC, MAR, RAM, IR, A, B, ALU, flags and OUT register.

Parameters:
- OPCODE_WIDTH, 4, width of the opcode field from the IR.
- STEP_WIDTH, 3, microstep counter width; must satisfy 2**STEP_WIDTH >= 5.
- SINGLE_STEP_EN, 0, when 1 the sequencer advances only on cycles with step_en high; when 0, step_en is ignored.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- step_en  in  1  advance qualifier, used only when SINGLE_STEP_EN=1
- opcode  in  OPCODE_WIDTH  current IR opcode
- flag_carry  in  1  registered ALU carry flag
- flag_zero  in  1  registered ALU zero flag
- microstep  out  STEP_WIDTH  current step (T0=0)
- oe_pc, oe_ir, oe_ram, oe_a, oe_alu  out  1 each  bus drivers; at most one high per cycle
- load_mar, load_ir, load_a, load_b, load_out, ram_we  out  1 each  bus sinks
- pc_enable, pc_load  out  1 each  PC increment / PC load from bus
- alu_sub  out  1  ALU subtract select
- flag_load  out  1  ALU flags capture
- instr_done  out  1  high in the final step of each instruction
- halted  out  1  CPU halted

Behaviour:
- Registered state: step counter and halted flag. All control outputs are combinational decode of (step, opcode, flags, halted) and must be glitch-free relative to clk.
- Reset: while reset=0 at a clock edge, step<=0 and halted<=0. During any cycle with reset=0, all control outputs and instr_done are forced to 0. Reset mid-instruction aborts it immediately.
- Advance: adv = !halted && (SINGLE_STEP_EN ? step_en : 1).
  - If adv and instr_done: step<=0.
  - Else if adv: step<=step+1.
  - Otherwise step holds and all strobes are 0. This prevents a repeated load or increment during a stall.
- Fetch, common to all instructions:
  - T0: oe_pc, load_mar.
  - T1: oe_ram, load_ir, pc_enable.
- Execute, from T2 onward (total instruction length in cycles given at the end of each line):
  - NOP 0x0: instr_done at T1; 2 cycles.
  - LDA 0x1: T2 oe_ir+load_mar; T3 oe_ram+load_a, done; 4 cycles.
  - ADD 0x2: T2 oe_ir+load_mar; T3 oe_ram+load_b; T4 oe_alu+load_a+flag_load, done; 5 cycles.
  - SUB 0x3: as ADD, with alu_sub asserted in T3 and T4.
  - STA 0x4: T2 oe_ir+load_mar; T3 oe_a+ram_we, done; 4 cycles.
  - LDI 0x5: T2 oe_ir+load_a, done; 3 cycles.
  - JMP 0x6: T2 oe_ir+pc_load, done; 3 cycles.
  - JC 0x7 / JZ 0x8: T2 oe_ir, plus pc_load only if flag_carry (JC) or flag_zero (JZ) is sampled high in T2. Done at T2 either way.
  - OUT 0xE: T2 oe_a+load_out, done; 3 cycles.
  - HLT 0xF: T2 done, halted<=1 on adv. While halted: all strobes 0, step=0, halted=1 until reset.
  - Undefined opcodes behave as NOP.
  - Opcode values compare on the low 4 bits. Upper opcode bits, when OPCODE_WIDTH>4, must be 0 for a defined instruction; otherwise the instruction is NOP.
- Guard: if step reaches 2**STEP_WIDTH-1 without instr_done, force instr_done (defensive wrap to T0).
- Same-step combinations such as pc_enable with load_ir, or load_a with flag_load, are legal. pc_load and pc_enable are never high together.

Decomposition:
- cpu_pkg:
  - opcode_t enum (NOP..HLT).
  - Step localparams T0_FETCH..T4.
  - ctrl_word_t packed struct holding every strobe.
  - OP_WIDTH constant.
- Sub-module microcode_decoder: purely combinational (step, opcode, flags) -> ctrl_word_t plus done.
- control_sequencer holds the step counter, the halted flag, and reset/stall gating.

Test Plan:
- reset=0 for 2 cycles, then 1, with opcode=0x5 (LDI) -> outputs 0 during reset; then T0 oe_pc+load_mar, T1 oe_ram+load_ir+pc_enable, T2 oe_ir+load_a+instr_done, then microstep=0.
- opcode=0x3 (SUB) -> 5-cycle sequence; alu_sub=1 in T3 and T4 only; flag_load=1 only in T4.
- JZ 0x8 with flag_zero=1 -> pc_load=1 in T2; repeat with flag_zero=0 -> pc_load=0; both return to T0 after 3 cycles.
- HLT 0xF -> halted=1 from the cycle after T2, all strobes 0 for 20 cycles; pulse reset=0 -> halted=0, restart at T0.
- SINGLE_STEP_EN=1, ADD with step_en high every 3rd cycle -> microstep changes only on enabled edges; load_b is never high on two consecutive cycles.
- Reset asserted during T3 of LDA -> load_a never asserted; microstep=0 after release.
